mul16_shift_add: RTL and testbench
==================================

Name: mul16_shift_add

Overview:
- Sequential unsigned 16x16 -> 32-bit multiplier that uses an external alu16 instance for every addition.
- Sits directly upstream of alu16: it drives A/B/Op/Cin each cycle and registers Y/Cout back.
- Uses the left-shift shift-add algorithm. A 32-bit add is split into two chained 16-bit ALU passes, low half then high half with carry.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- OP_ADD, 3'b000, alu16 opcode driven on alu_op for addition.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_a  input  16  multiplicand M (unsigned)
- in_b  input  16  multiplier Q (unsigned)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out_p  output  32  product in_a*in_b
- busy  output  1  high in any state except IDLE
- alu_a  output  16  to alu16 A
- alu_b  output  16  to alu16 B
- alu_op  output  3  to alu16 Op
- alu_cin  output  1  to alu16 Cin
- alu_y  input  16  from alu16 Y (combinational, same cycle)
- alu_cout  input  1  from alu16 Cout (combinational, same cycle)

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state=IDLE; P, M, Q, cnt, carry reg cleared to 0.
  - out_valid=0, out_p=0, busy=0, in_ready=1.
  - rst has priority over every other event, including mid-multiply and DONE. Any in-flight operation is discarded with no output.
- ALU drive:
  - alu_op=OP_ADD in every state.
  - In all states except ADD_LO and ADD_HI: alu_a=0, alu_b=0, alu_cin=0.
- IDLE:
  - in_ready=1.
  - in_valid=1 at an edge: M<=in_a, Q<=in_b, P<=0, cnt<=0, next state SHIFT.
- SHIFT:
  - P<=P<<1 (internal, bit 0 filled with 0); Q<=Q<<1; cnt<=cnt+1.
  - If old Q[15]=1, next state ADD_LO.
  - Otherwise, if cnt==15 go to DONE, else stay in SHIFT.
- ADD_LO:
  - Drive alu_a=P[15:0], alu_b=M, alu_cin=0.
  - At the edge: P[15:0]<=alu_y, carry<=alu_cout; next state ADD_HI.
- ADD_HI:
  - Drive alu_a=P[31:16], alu_b=0, alu_cin=carry.
  - At the edge: P[31:16]<=alu_y; alu_cout is ignored, since the product cannot exceed 32 bits.
  - Next state is DONE if cnt==16 (all bits consumed), else SHIFT.
- DONE:
  - out_valid=1, out_p=P, in_ready=0.
  - out_ready=1 at an edge moves to IDLE, with out_valid low from that edge.
  - out_p is held stable while out_valid=1 and out_ready=0; backpressure is unlimited.
- out_p outside DONE: holds the last product (0 after reset).
- cnt is 5 bits, range 0..16, and never wraps.
- Latency: out_valid rises exactly 16 + 2*popcount(in_b) edges after the accepting edge.
  - Range is 16 (b=0) to 48 (b=0xFFFF).
  - The result is independent of in_a.
- Throughput:
  - No new operand is accepted until the product is consumed.
  - The earliest next accept is the cycle after the out_ready handshake (IDLE one cycle). in_ready is combinational from state.
- in_valid while busy: ignored, with no effect on the operation in progress.
- in_a and in_b are sampled only at the accepting edge; later changes have no effect.

Test Plan:
- 5 x 3: a=0x0005, b=0x0003, out_ready=1 -> out_p=0x0000000F; out_valid 20 edges after accept; ADD_LO drives alu_a=P[15:0], alu_b=0x0005.
- Full-scale: a=0xFFFF, b=0xFFFF -> out_p=0xFFFE0001 after 48 edges. Checks carry chaining, e.g. low pass 0xFFFE+0xFFFF gives Cout=1 into ADD_HI.
- Zero and boundary:
  - a=0x1234, b=0 -> out_p=0, latency 16, ALU ports held at 0.
  - a=0, b=0x8000 -> out_p=0, latency 18.
  - a=0x0001, b=0x8000 -> out_p=0x00008000, latency 18.
- Backpressure: a=0x00FF, b=0x0002 with out_ready=0 for 10 cycles -> out_valid stays 1, out_p stable at 0x000001FE, in_ready=0, and an extra in_valid pulse is ignored. Raising out_ready returns to IDLE next edge.
- Reset mid-operation: assert rst for one edge 7 cycles after accepting a=0x1234, b=0x5678 -> IDLE, out_valid=0, out_p=0. Then a=0x1234, b=0x5678 -> 0x06260060.
- Back-to-back: hold in_valid=1 and out_ready=1 with pairs (0x00FF,0x0001), (0x00FF,0x0002) -> outputs 0x000000FF then 0x000001FE in order. Each accept occurs only in IDLE, one cycle after the previous handshake.

Source files
------------

// File: rtl/mul16_shift_add.sv
// mul16_shift_add: sequential unsigned 16x16->32 shift-add multiplier
// that borrows an external alu16 for every addition.
module mul16_shift_add #(
  parameter logic [2:0] OP_ADD = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        busy,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_y,
  input  logic        alu_cout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ADD_LO,
    S_ADD_HI,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_p;
  logic [15:0] r_m;
  logic [15:0] r_q;
  logic [4:0]  r_cnt;
  logic        r_carry;
  logic [31:0] r_out;

  logic        w_lo;
  logic        w_hi;
  logic [31:0] w_p_shl;

  assign w_lo    = (r_state == S_ADD_LO);
  assign w_hi    = (r_state == S_ADD_HI);
  assign w_p_shl = {r_p[30:0], 1'b0};

  // ALU port is idle (all zero) outside the two add passes
  assign alu_op  = OP_ADD;
  assign alu_a   = w_lo ? r_p[15:0]  :
                   w_hi ? r_p[31:16] : 16'h0000;
  assign alu_b   = w_lo ? r_m : 16'h0000;
  assign alu_cin = w_hi & r_carry;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_p     = r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_out   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_m     <= in_a;
            r_q     <= in_b;
            r_p     <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_p   <= w_p_shl;
          r_q   <= {r_q[14:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_q[15]) begin
            r_state <= S_ADD_LO;
          end else if (r_cnt == 5'd15) begin
            r_out   <= w_p_shl;
            r_state <= S_DONE;
          end
        end
        S_ADD_LO: begin
          r_p[15:0] <= alu_y;
          r_carry   <= alu_cout;
          r_state   <= S_ADD_HI;
        end
        S_ADD_HI: begin
          // high pass cannot overflow, carry-out is dropped
          r_p[31:16] <= alu_y;
          if (r_cnt == 5'd16) begin
            r_out   <= {alu_y, r_p[15:0]};
            r_state <= S_DONE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_shift_add.sv
// tb_mul16_shift_add: directed checks of mul16_shift_add
// with a behavioural alu16 adder closing the loop.
module tb_mul16_shift_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        busy;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_y;
  logic        alu_cout;

  int checks = 0;
  int errors = 0;
  int lat;
  int lo_first_lat;
  logic [15:0] lo_first_a;
  logic [15:0] lo_first_b;
  logic [15:0] lo_last_a;
  bit saw_cin;
  bit alu_nz;
  bit op_nz;

  always #5 clk = ~clk;

  assign {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_cin};

  mul16_shift_add dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_cin   (alu_cin),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    chk("acc_ready", {31'b0, in_ready}, 32'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("acc_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    lat = 0;
    lo_first_lat = -1;
    saw_cin = 1'b0;
    alu_nz = 1'b0;
    op_nz = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
      if (alu_op !== 3'b000) op_nz = 1'b1;
      if (alu_a !== 0 || alu_b !== 0 || alu_cin !== 0) alu_nz = 1'b1;
      if (alu_cin === 1'b1) saw_cin = 1'b1;
      if (alu_b !== 0) begin
        if (lo_first_lat < 0) begin
          lo_first_lat = lat;
          lo_first_a = alu_a;
          lo_first_b = alu_b;
        end
        lo_last_a = alu_a;
      end
    end
    chk("done_valid", {31'b0, out_valid}, 32'd1);
    chk("alu_op", {31'b0, op_nz}, 32'd0);
  endtask

  task automatic handshake(input logic [31:0] p);
    out_ready = 1'b1;
    step();
    chk("hs_valid", {31'b0, out_valid}, 32'd0);
    chk("hs_ready", {31'b0, in_ready}, 32'd1);
    chk("hs_hold_p", out_p, p);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_p", out_p, 32'h0);
    chk("rst_alu", {alu_a, alu_b}, 32'h0);

    // 5 x 3
    out_ready = 1'b1;
    accept(16'h0005, 16'h0003);
    wait_done();
    chk("5x3_p", out_p, 32'h0000000F);
    chk("5x3_lat", lat, 20);
    chk("5x3_lo_lat", lo_first_lat, 15);
    chk("5x3_lo_a0", {16'h0, lo_first_a}, 32'h0);
    chk("5x3_lo_b", {16'h0, lo_first_b}, 32'h5);
    chk("5x3_lo_a1", {16'h0, lo_last_a}, 32'hA);
    handshake(32'h0000000F);

    // full scale, carry chaining
    step();
    accept(16'hFFFF, 16'hFFFF);
    wait_done();
    chk("ff_p", out_p, 32'hFFFE0001);
    chk("ff_lat", lat, 48);
    chk("ff_cin", {31'b0, saw_cin}, 32'd1);
    handshake(32'hFFFE0001);

    // zero and boundary
    step();
    accept(16'h1234, 16'h0000);
    wait_done();
    chk("b0_p", out_p, 32'h0);
    chk("b0_lat", lat, 16);
    chk("b0_alu_idle", {31'b0, alu_nz}, 32'd0);
    handshake(32'h0);

    step();
    accept(16'h0000, 16'h8000);
    wait_done();
    chk("a0_p", out_p, 32'h0);
    chk("a0_lat", lat, 18);
    handshake(32'h0);

    step();
    accept(16'h0001, 16'h8000);
    wait_done();
    chk("1x8000_p", out_p, 32'h00008000);
    chk("1x8000_lat", lat, 18);
    handshake(32'h00008000);

    // backpressure with a stray in_valid pulse
    step();
    out_ready = 1'b0;
    accept(16'h00FF, 16'h0002);
    wait_done();
    chk("bp_p0", out_p, 32'h000001FE);
    chk("bp_lat", lat, 18);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_valid = 1'b1;
        in_a = 16'hAAAA;
        in_b = 16'h5555;
      end
      step();
      in_valid = 1'b0;
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_p", out_p, 32'h000001FE);
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
    end
    handshake(32'h000001FE);

    // reset mid-operation
    step();
    accept(16'h1234, 16'h5678);
    for (int i = 0; i < 7; i++) step();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_p", out_p, 32'h0);
    for (int i = 0; i < 3; i++) step();
    chk("mid_rst_idle", {31'b0, out_valid}, 32'd0);
    accept(16'h1234, 16'h5678);
    wait_done();
    chk("rerun_p", out_p, 32'h06260060);
    chk("rerun_lat", lat, 32);
    handshake(32'h06260060);

    // back-to-back with in_valid and out_ready held high
    step();
    out_ready = 1'b1;
    accept(16'h00FF, 16'h0001);
    in_valid = 1'b1;
    in_a = 16'h00FF;
    in_b = 16'h0002;
    wait_done();
    chk("b2b_p0", out_p, 32'h000000FF);
    chk("b2b_lat0", lat, 18);
    step();
    chk("b2b_idle", {31'b0, in_ready}, 32'd1);
    chk("b2b_nv", {31'b0, out_valid}, 32'd0);
    step();
    chk("b2b_acc", {31'b0, busy}, 32'd1);
    wait_done();
    chk("b2b_p1", out_p, 32'h000001FE);
    chk("b2b_lat1", lat, 18);
    in_valid = 1'b0;
    step();
    chk("b2b_end", {31'b0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
